// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pkg
//  Purpose  : Shared types, constants and helpers for the data-memory
//             responder (FSM state encoding, word width, byte-lane merge).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int WORD_BYTES = 4;

    // Replace each byte lane of old_word whose enable is set with the
    // corresponding lane of new_word.
    function automatic logic [31:0] be_merge(
        input logic [31:0]           old_word,
        input logic [31:0]           new_word,
        input logic [WORD_BYTES-1:0] be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_word_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dm_word_ram
//  Purpose  : 2**ADDR_WIDTH x 32-bit word storage. Synchronous read,
//             synchronous byte-enable write, asynchronous clear of the whole
//             array (and the read register) on reset.
//  Ports    : clk, reset      - clock, async active-high clear
//             raddr / rdata   - read index, registered read word
//             we, waddr,
//             wdata, be       - write strobe, index, data, byte enables
//  Revision : 1.0 - initial release
// ============================================================================
module dm_word_ram
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] r_mem [c_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            // Read returns the pre-write contents when raddr == waddr.
            rdata <= r_mem[raddr];
            if (we) begin
                r_mem[waddr] <= be_merge(r_mem[waddr], wdata, be);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Responder-side data memory for the CPU load/store port. One
//             request at a time over valid/ready, WAIT_CYCLES wait states,
//             registered response with error flag, one-cycle store trace.
//  Ports    : clk, reset                    - clock, async active-high reset
//             req_valid/req_ready           - request handshake
//             req_write, req_addr,
//             req_wdata, req_be, req_pc     - request fields
//             resp_valid/resp_ready         - response handshake
//             resp_rdata, resp_err          - response payload
//             trace_valid, trace_pc,
//             trace_addr, trace_data        - committed-store trace record
//  Revision : 1.0 - initial release
// ============================================================================
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    dm_state_t   r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_pc;

    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [31:0]           w_ram_rdata;
    logic                  w_err;
    logic                  w_access;
    logic                  w_we;
    logic [31:0]           w_merged;

    assign req_ready = (r_state == IDLE);

    // While idle the RAM is read at the incoming address so the old word is
    // already registered one cycle after acceptance; afterwards it keeps
    // re-reading the latched address. With only one outstanding request no
    // write can intervene, so the value at the access edge is current even
    // with WAIT_CYCLES = 0.
    assign w_raddr  = (r_state == IDLE) ? req_addr[ADDR_WIDTH+1:2]
                                        : r_addr[ADDR_WIDTH+1:2];

    assign w_err    = (r_addr[1:0] != 2'b00) ||
                      ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_we     = w_access && r_write && !w_err && (r_be != 4'd0);
    assign w_merged = be_merge(w_ram_rdata, r_wdata, r_be);

    dm_word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .raddr (w_raddr),
        .rdata (w_ram_rdata),
        .we    (w_we),
        .waddr (r_addr[ADDR_WIDTH+1:2]),
        .wdata (r_wdata),
        .be    (r_be)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_pc        <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_pc    <= req_pc;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        if (w_err) begin
                            resp_err <= 1'b1;
                        end else if (r_write) begin
                            if (r_be != 4'd0) begin
                                trace_valid <= 1'b1;
                                trace_pc    <= r_pc;
                                trace_addr  <= {r_addr[31:2], 2'b00};
                                trace_data  <= w_merged;
                            end
                        end else begin
                            resp_rdata <= w_ram_rdata;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_responder
//  Purpose  : Self-checking bench for dm_responder: directed scenarios plus
//             randomized loads/stores against a word-array reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int AW    = 10;
    localparam int WC    = 2;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .req_pc      (req_pc),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, follow it to its response, optionally stall the
    // response for 'hold' cycles (with a stray request offered meanwhile),
    // then complete the handshake. Expectations come from the word model.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] pc, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        exp_tv;
        logic [31:0] exp_td;
        logic [31:0] mask;
        logic [31:0] old_w;
        logic        seen_trace;
        logic [31:0] s_rd;
        logic        s_err;
        int          n;
        int          idx;

        exp_err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        exp_rd  = 32'd0;
        exp_tv  = 1'b0;
        exp_td  = 32'd0;
        if (!exp_err) begin
            idx   = int'(addr / 4);
            old_w = mdl[idx];
            if (wr) begin
                mask = 32'd0;
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) mask = mask | (32'hFF << (8 * l));
                end
                exp_td   = (old_w & ~mask) | (wd & mask);
                exp_tv   = (be != 4'd0);
                mdl[idx] = exp_td;
            end else begin
                exp_rd = old_w;
            end
        end

        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_pc    = pc;
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        req_pc    = $urandom;
        chk("req_ready_busy", 32'(req_ready), 32'd0);

        seen_trace = 1'b0;
        n = 1;
        while (!resp_valid && n < 40) begin
            if (trace_valid) seen_trace = 1'b1;
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(WC + 2));
        chk("early_trace", 32'(seen_trace), 32'd0);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("trace_valid", 32'(trace_valid), 32'(exp_tv));
        if (exp_tv) begin
            chk("trace_pc", trace_pc, pc);
            chk("trace_addr", trace_addr, addr);
            chk("trace_data", trace_data, exp_td);
        end

        s_rd  = resp_rdata;
        s_err = resp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'($urandom_range(0, 15)) << 2;
            req_wdata = $urandom;
            req_be    = 4'hF;
            step();
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, s_rd);
            chk("hold_err", 32'(resp_err), 32'(s_err));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_trace", 32'(trace_valid), 32'd0);
        end

        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_err", 32'(resp_err), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_trace", 32'(trace_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r;

        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        req_pc     = 32'd0;
        resp_ready = 1'b0;
        repeat (3) step();

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_trace_valid", 32'(trace_valid), 32'd0);
        chk("rst_trace_pc", trace_pc, 32'd0);
        chk("rst_trace_addr", trace_addr, 32'd0);
        chk("rst_trace_data", trace_data, 32'd0);
        reset = 1'b0;
        step();

        // Directed scenarios
        do_req(1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'h0000_1000, 0);
        do_req(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_3000, 0);
        do_req(1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h0000_3004, 0);
        chk("dir_store_full", mdl[1], 32'hDEAD_BEEF);
        do_req(1'b1, 32'h0000_0004, 32'h0000_1234, 4'b0011, 32'h0000_3008, 0);
        do_req(1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h0000_300C, 0);
        chk("dir_store_part", mdl[1], 32'hDEAD_1234);
        do_req(1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 4'hF, 32'h0000_3010, 0);
        do_req(1'b0, 32'h0000_1000, 32'd0, 4'hF, 32'h0000_3014, 0);
        do_req(1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h0000_3018, 5);

        // Reset during the second WAIT cycle of a store to 0x8
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0008;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        req_pc    = 32'h0000_4000;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        #2;
        chk("midrst_trace", 32'(trace_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp", 32'(resp_valid), 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        step();
        chk("midrst_trace2", 32'(trace_valid), 32'd0);
        do_req(1'b0, 32'h0000_0008, 32'd0, 4'hF, 32'h0000_4004, 0);
        do_req(1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h0000_4008, 0);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 6) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 7) a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
            else             a = 32'($urandom_range(DEPTH - 4, DEPTH - 1)) << 2;
            do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
# dm_responder

Responder-side data memory for the CPU's load/store port: accepts one word-granular request at a time over a valid/ready handshake, applies configurable wait states, and returns read data or an error. It replaces the zero-latency data memory when the datapath is split from storage, so that a multi-cycle CPU can issue requests into it. It also emits a one-cycle trace record for every committed store, in the `@pc: *addr <= data` form the grading flow expects.

## Interface
- `ADDR_WIDTH`, default 10: word-index width. Storage holds 2**ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: extra wait cycles before the access commits. Legal range is 0..15.
- `clk` input, 1 bit: the only clock. All logic is rising-edge.
- `reset` input, 1 bit: asynchronous, active-high. It clears the FSM, all outputs, and the entire storage array to 0.
- `req_valid` input, 1 bit: a request is present.
- `req_ready` output, 1 bit: the responder can accept a request.
- `req_write` input, 1 bit: 1 for a store, 0 for a load.
- `req_addr` input, 32 bits: byte address.
- `req_wdata` input, 32 bits: store data.
- `req_be` input, 4 bits: byte enables. Bit i enables byte lane [8i+7:8i].
- `req_pc` input, 32 bits: PC of the issuing instruction. Used for trace only.
- `resp_valid` output, 1 bit: a response is present.
- `resp_ready` input, 1 bit: the initiator accepts the response.
- `resp_rdata` output, 32 bits: load data. It is 0 for stores and for errors.
- `resp_err` output, 1 bit: the request was misaligned or out of range.
- `trace_valid` output, 1 bit: one-cycle pulse marking a committed store.
- `trace_pc`, `trace_addr`, `trace_data` outputs, 32 bits each: the store's PC, its word-aligned byte address, and the full merged word after the write.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **`req_ready`:** equals (state == IDLE). It is combinational from the state register.
- **IDLE:** on `req_valid && req_ready`, latch `write`, `addr`, `wdata`, `be`, and `pc`. Load `cnt = WAIT_CYCLES` and go to WAIT.
- **WAIT, `cnt != 0`:** decrement `cnt` each cycle.
- **WAIT, `cnt == 0`:** perform the access on this edge and go to RESP.
- **Error check:** the request is an error if `addr[1:0] != 0` or `addr[31:2] >= 2**ADDR_WIDTH`.
  - Storage is unchanged and no trace is emitted.
  - The response is `resp_err = 1`, `resp_rdata = 0`.
- **Load:** `resp_rdata` = the word at `addr[ADDR_WIDTH+1:2]`, sampled at the access edge.
- **Store:** each lane with `be[i] = 1` is overwritten; the other lanes keep their old value. `resp_rdata = 0`.
  - With `be != 0`, `trace_valid` pulses for exactly the first RESP cycle.
  - With `be == 0`, there is no change and no trace.
- **RESP:**
  - `resp_valid = 1`. `resp_rdata` and `resp_err` are registered and hold stable until the handshake.
  - On `resp_ready`, clear `resp_valid`, `resp_rdata`, and `resp_err`, and go to IDLE.
- **Strictly one outstanding request.** `req_valid` is ignored outside IDLE. The initiator must hold its request fields stable only until acceptance.
- **Reset in WAIT:** the access is abandoned, storage is cleared by reset, and no trace is emitted.
- **Reset in RESP:** the response is dropped. After reset deasserts the block is in IDLE.
- **Reset values:** state IDLE, so `req_ready = 1`. `resp_valid`, `resp_rdata`, `resp_err`, `trace_valid`, `trace_pc`, `trace_addr`, and `trace_data` are all 0.

## Timing
- **Load latency:** with acceptance in cycle T, `resp_valid` first goes high in cycle T + WAIT_CYCLES + 2. With the default `WAIT_CYCLES = 2`, that is T+4.
- **Store commit:** the store commits on the edge that ends cycle T + WAIT_CYCLES + 1. The trace is visible in cycle T + WAIT_CYCLES + 2.
- **Back-to-back throughput:** the earliest next acceptance is the cycle after the response handshake. Peak rate is one request per WAIT_CYCLES + 3 cycles.
- **No combinational paths** from `req_*` or `resp_ready` to any output, except `req_ready`, which depends on state only.

## Structure
- **Package `dm_pkg`:**
  - state enum `{IDLE, WAIT, RESP}`;
  - the `WORD_BYTES = 4` constant;
  - a pure function `be_merge(old, new, be)`.
- **Sub-module `dm_word_ram`:**
  - a 2**ADDR_WIDTH × 32 array;
  - synchronous byte-enable write and synchronous read;
  - asynchronous clear on `reset`;
  - no handshake logic.
- **`dm_responder`:** the FSM, wait counter, request latch, error check, and the response and trace registers.

## Test plan
1. **Load after reset:** release reset, then load `0x00000010` → after 4 cycles, `resp_valid = 1`, `resp_rdata = 0`, `resp_err = 0`. `req_ready` returns to 1 one cycle after the handshake.
2. **Full-word store and readback:** store `0x00000004` with data `0xDEADBEEF`, `be = 1111`, `pc = 0x00003000` → a single-cycle trace (`0x00003000`, `0x00000004`, `0xDEADBEEF`). A following load of `0x4` returns `0xDEADBEEF`.
3. **Partial store:** store `0x4` with data `0x00001234`, `be = 0011` → trace data is `0xDEAD1234`, and readback is `0xDEAD1234`.
4. **Errors:** store `0x6` and load `0x00001000` (with `ADDR_WIDTH = 10`) → both return `resp_err = 1` and `resp_rdata = 0`, with no trace. Word `0x4` still reads `0xDEAD1234`.
5. **Backpressure:** hold `resp_ready = 0` for 5 cycles during a load response → `resp_valid`, `resp_rdata`, and `resp_err` stay stable, and `req_ready` stays 0. A new `req_valid` pulse in that window is not accepted.
6. **Reset mid-operation:** assert `reset` in the second WAIT cycle of a store to `0x8` → no trace, state IDLE, `req_ready = 1`. A load of `0x8` returns 0.
